// File: rtl/mul_pkg.sv
// Shared multiplier-side definitions: result word geometry, reader FSM states,
// and the optional mod-q lane mask used by the result reader.
package mul_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int LANES          = 4;
    localparam int WORD_W         = DATA_WIDTH * LANES;
    localparam int RR_ADDR_STRIDE = 8;
    localparam int RR_FIFO_DEPTH  = 2;
    localparam int LOGQ           = 15;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RR_IDLE,
        RR_READ,
        RR_DRAIN,
        RR_DONE
    } rr_state_t;

    // Low LOGQ bits of a lane; q is a power of two so AND is the reduction.
    localparam logic [DATA_WIDTH-1:0] LANE_MASK =
        {{(DATA_WIDTH-LOGQ){1'b0}}, {LOGQ{1'b1}}};

    function automatic word_t mask_word(input word_t w);
        word_t r;
        r = w;
        for (int l = 0; l < LANES; l++) begin
            r[l*DATA_WIDTH +: DATA_WIDTH] = w[l*DATA_WIDTH +: DATA_WIDTH] & LANE_MASK;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_fifo.sv
// Small synchronous FIFO carrying a result word plus its end-of-transfer tag.
// Writes are bypass-free: a pushed entry becomes the head on the next cycle.
// The caller guarantees no push when full without a pop, and no pop when empty.
module rr_fifo
    import mul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [WORD_W-1:0] head_data,
    output logic              head_last,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem_data [DEPTH];
    logic              mem_last [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

    // Storage write; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= push_last;
        end
    end

    // Pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_reader.sv
// Result BRAM reader: issues reads for a block of result words and streams them
// out over valid/ready at one word per cycle, hiding the BRAM's 1-cycle latency
// with a small credit-controlled output FIFO.
// Build option: define RESULT_READER_MASK_EN to reduce every output lane mod 2^LOGQ.
module result_reader
    import mul_pkg::*;
#(
    parameter int FIFO_DEPTH  = RR_FIFO_DEPTH,
    parameter int ADDR_STRIDE = RR_ADDR_STRIDE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [15:0]       num_words,
    output logic              busy,
    output logic              done,
    output logic [31:0]       addr_rd,
    output logic              ren,
    input  logic [WORD_W-1:0] bram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W  = CNT_W + 1;
    localparam logic [CR_W-1:0] DEPTH_C = CR_W'(FIFO_DEPTH);

    rr_state_t         state;
    logic [15:0]       num_q;
    logic [15:0]       issued;
    logic [31:0]       next_addr;
    logic [31:0]       last_addr;
    logic              inflight;
    logic              inflight_last;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] head_data;
    logic              head_last;
    logic              pop;
    logic              issue_last;
    logic [CR_W-1:0]   credit;

    assign m_valid    = (count != '0);
    assign pop        = m_valid && m_ready;
    assign issue_last = (issued == num_q - 16'd1);

    // Slots that will be occupied next cycle. Counting this cycle's pop keeps
    // reads flowing back-to-back under continuous m_ready with only two entries.
    assign credit = {1'b0, count} - CR_W'(pop) + CR_W'(inflight);

    assign ren     = (state == RR_READ) && (credit < DEPTH_C);
    assign addr_rd = ren ? next_addr : last_addr;

    rr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (bram_rdata),
        .push_last (inflight_last),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .count     (count)
    );

    // Empty FIFO presents zeros so stale storage never leaks after reset.
`ifdef RESULT_READER_MASK_EN
    assign m_data = m_valid ? mask_word(head_data) : '0;
`else
    assign m_data = m_valid ? head_data : '0;
`endif
    assign m_last = m_valid && head_last;

    // Read-issue datapath: address walk, issue count and the 1-deep in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q         <= '0;
            issued        <= '0;
            next_addr     <= '0;
            last_addr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= ren;
            inflight_last <= ren && issue_last;
            if (state == RR_IDLE && start) begin
                num_q     <= num_words;
                issued    <= '0;
                next_addr <= base_addr;
            end else if (ren) begin
                last_addr <= next_addr;
                next_addr <= next_addr + 32'(ADDR_STRIDE);
                issued    <= issued + 16'd1;
            end
        end
    end

    // Transfer FSM with registered busy/done. A zero-length transfer passes
    // through DRAIN, which exits at once, so done lands 2 cycles after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RR_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RR_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= (num_words == 16'd0) ? RR_DRAIN : RR_READ;
                    end
                end
                RR_READ: begin
                    if (ren && issue_last) state <= RR_DRAIN;
                end
                RR_DRAIN: begin
                    // Nothing in flight and the FIFO empties at this edge.
                    if (credit == '0) begin
                        state <= RR_DONE;
                        done  <= 1'b1;
                    end
                end
                RR_DONE: begin
                    state <= RR_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= RR_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
